ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer for the single-port 32x8 lab RAM (registered address/data/wren, q one clock later).
//  Accepts read/write commands from two clients via req/gnt handshake, drives RAM ports, returns read data with rvalid.
//  Sits between the switch/display front end (r0) and an auxiliary client such as a scanner (r1), and owns all RAM ports.
// PARAMETERS
//  ADDR_W   5   RAM address width (32 words)
//  DATA_W   8   RAM data width
// PORTS
//  clock      in   1       single clock; RAM shares it
//  reset      in   1       synchronous, active-high
//  r0_req     in   1       client 0 command valid
//  r0_we      in   1       1=write, 0=read
//  r0_addr    in   ADDR_W  client 0 address
//  r0_wdata   in   DATA_W  client 0 write data
//  r0_gnt     out  1       1-cycle pulse: command accepted
//  r0_rvalid  out  1       1-cycle pulse: rdata holds client 0 read result
//  r1_req/r1_we/r1_addr/r1_wdata/r1_gnt/r1_rvalid   same as r0_*, for client 1
//  rdata      out  DATA_W  registered read data; meaningful only with rN_rvalid
//  ram_addr   out  ADDR_W  to RAM address
//  ram_data   out  DATA_W  to RAM data
//  ram_wren   out  1       to RAM wren
//  ram_q      in   DATA_W  from RAM q
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, cmd regs 0, last_owner=1 (r0 wins first tie); in-flight op dropped.
//  FSM IDLE -> ISSUE -> (write) IDLE | (read) WAIT -> IDLE.
//  IDLE: if any req, pick winner, latch we/addr/wdata/owner into cmd regs, go ISSUE; else stay.
//  ISSUE: ram_addr/ram_data from cmd regs; ram_wren = cmd_we & ~reset; rOwner_gnt=1 this cycle only.
//  WAIT: RAM output valid; at end of WAIT rdata<=ram_q, rOwner_rvalid<=1 (pulses during next IDLE).
//  ram_addr/ram_data hold cmd regs in all states; ram_wren=0 outside ISSUE.
//  Throughput: write 2 cycles, read 3 cycles; req sampled only in IDLE; IDLE overlapping an rvalid may accept a new cmd.
//  Latency: req seen in IDLE at edge k -> gnt cycle k+1 -> read rvalid/rdata cycle k+3.
//  Client rule: hold req/we/addr/wdata stable until gnt; may drop or change them the cycle after gnt.
//  Tie (both req in IDLE): see CONFIGURATION. last_owner updated on every grant.
//  Addresses pass through unmodified; no wrap logic; 5'h1F and 5'h00 are ordinary.
//  Reset in ISSUE: wren suppressed, no write. Reset in WAIT: no rvalid, rdata unchanged (0 after reset).
//  gnt and rvalid never asserted for both clients in the same cycle.
// CONFIGURATION
//  RAM_ARB_RR_EN defined: round robin; on tie grant client != last_owner.
//  RAM_ARB_RR_EN undefined: fixed priority r0 > r1; r1 may starve; last_owner kept but unused.
// STRUCTURE
//  Package ram_arb_pkg: ADDR_W/DATA_W defaults, state enum (IDLE, ISSUE, WAIT), owner id typedef (1 bit).
//  Sub-module ram_arb_pick: combinational 2-way pick (req0, req1, last_owner -> winner, any); macro lives here only.
//  Top: FSM, cmd regs, rdata/rvalid regs, RAM port drive.
// TESTING
//  Bench models RAM as 32x8 array with registered address, q one clock later.
//  1 reset held 2 cycles mid-traffic -> all outputs 0, busy=0, ram_wren=0 on cycle after.
//  2 r0 write 5'h03 8'hA5 -> next cycle r0_gnt=1, ram_wren=1, ram_addr=03, ram_data=A5; then r0 read 03 -> r0_rvalid, rdata=A5 two cycles after gnt.
//  3 preload [1]=11,[2]=22; r0 read 1 + r1 read 2 same cycle -> RR: gnt0, rvalid0/11, then gnt1, rvalid1/22.
//  4 r0 continuous reads + r1 held req -> RR_EN: grants alternate r0,r1,r0...; undefined: r1_gnt never asserts.
//  5 r1 writes 5'h1F=8'h7E then 5'h00=8'h81 back-to-back -> two ISSUE cycles 2 apart; readback 7E, 81.
//  6 reset in ISSUE of write 5'h04=8'hFF -> ram_wren=0, [4] unchanged; reset in WAIT of read -> no rvalid.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared widths, FSM state encoding and owner id for the two-client RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned DefAddrW = 5;
    localparam int unsigned DefDataW = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_t;

    typedef logic owner_t;

    localparam owner_t OwnerR0 = 1'b0;
    localparam owner_t OwnerR1 = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational 2-way pick between client requests.
// RAM_ARB_RR_EN selects round robin on ties; otherwise client 0 has fixed priority.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic   i_req0,
    input  logic   i_req1,
    input  owner_t i_last_owner,
    output owner_t o_winner,
    output logic   o_any
);

`ifdef RAM_ARB_RR_EN
    always_comb begin
        o_any    = i_req0 | i_req1;
        o_winner = OwnerR0;
        if (i_req0 && i_req1) begin
            // Tie goes to whoever was not granted last.
            o_winner = (i_last_owner == OwnerR0) ? OwnerR1 : OwnerR0;
        end else if (i_req1) begin
            o_winner = OwnerR1;
        end
    end
`else
    logic w_unused_last_owner;
    assign w_unused_last_owner = i_last_owner;

    always_comb begin
        o_any    = i_req0 | i_req1;
        o_winner = OwnerR0;
        if (!i_req0 && i_req1) begin
            o_winner = OwnerR1;
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-client arbiter/sequencer owning all ports of a single-port registered RAM.
// Tie policy comes from ram_arb_pick (RAM_ARB_RR_EN = round robin, else r0 priority).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_r0_req,
    input  logic              i_r0_we,
    input  logic [ADDR_W-1:0] i_r0_addr,
    input  logic [DATA_W-1:0] i_r0_wdata,
    output logic              o_r0_gnt,
    output logic              o_r0_rvalid,
    input  logic              i_r1_req,
    input  logic              i_r1_we,
    input  logic [ADDR_W-1:0] i_r1_addr,
    input  logic [DATA_W-1:0] i_r1_wdata,
    output logic              o_r1_gnt,
    output logic              o_r1_rvalid,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_data,
    output logic              o_ram_wren,
    input  logic [DATA_W-1:0] i_ram_q,
    output logic              o_busy
);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_cmd_load;
    logic              w_any;
    owner_t            w_winner;

    logic              r_cmd_we;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [DATA_W-1:0] r_cmd_wdata;
    owner_t            r_cmd_owner;
    owner_t            r_last_owner;

    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic              w_issue;

    ram_arb_pick u_pick (
        .i_req0       (i_r0_req),
        .i_req1       (i_r1_req),
        .i_last_owner (r_last_owner),
        .o_winner     (w_winner),
        .o_any        (w_any)
    );

    assign w_sel_we    = (w_winner == OwnerR1) ? i_r1_we    : i_r0_we;
    assign w_sel_addr  = (w_winner == OwnerR1) ? i_r1_addr  : i_r0_addr;
    assign w_sel_wdata = (w_winner == OwnerR1) ? i_r1_wdata : i_r0_wdata;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cmd_load   = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_state_next = StIssue;
                    w_cmd_load   = 1'b1;
                end
            end
            StIssue: w_state_next = r_cmd_we ? StIdle : StWait;
            StWait:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // last_owner resets to r1 so that r0 wins the first round-robin tie.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cmd_we     <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
            r_cmd_owner  <= OwnerR0;
            r_last_owner <= OwnerR1;
        end else if (w_cmd_load) begin
            r_cmd_we     <= w_sel_we;
            r_cmd_addr   <= w_sel_addr;
            r_cmd_wdata  <= w_sel_wdata;
            r_cmd_owner  <= w_winner;
            r_last_owner <= w_winner;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rdata   <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= (r_state == StWait) && (r_cmd_owner == OwnerR0);
            r_rvalid1 <= (r_state == StWait) && (r_cmd_owner == OwnerR1);
            if (r_state == StWait) begin
                r_rdata <= i_ram_q;
            end
        end
    end

    // Reset during ISSUE must not reach the RAM or the clients.
    assign w_issue     = (r_state == StIssue) && !i_reset;

    assign o_r0_gnt    = w_issue && (r_cmd_owner == OwnerR0);
    assign o_r1_gnt    = w_issue && (r_cmd_owner == OwnerR1);
    assign o_r0_rvalid = r_rvalid0;
    assign o_r1_rvalid = r_rvalid1;
    assign o_rdata     = r_rdata;
    assign o_ram_addr  = r_cmd_addr;
    assign o_ram_data  = r_cmd_wdata;
    assign o_ram_wren  = w_issue && r_cmd_we;
    assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a registered 32x8 RAM model and a read scoreboard.
module tb_ram_arbiter;

    logic       clk;
    logic       rst;
    logic       r0_req, r0_we, r1_req, r1_we;
    logic [4:0] r0_addr, r1_addr;
    logic [7:0] r0_wdata, r1_wdata;
    logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [7:0] rdata;
    logic [4:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_wren;
    logic [7:0] ram_q;
    logic       busy;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    typedef struct {
        int         owner;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    ram_arbiter u_dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_r0_req   (r0_req),
        .i_r0_we    (r0_we),
        .i_r0_addr  (r0_addr),
        .i_r0_wdata (r0_wdata),
        .o_r0_gnt   (r0_gnt),
        .o_r0_rvalid(r0_rvalid),
        .i_r1_req   (r1_req),
        .i_r1_we    (r1_we),
        .i_r1_addr  (r1_addr),
        .i_r1_wdata (r1_wdata),
        .o_r1_gnt   (r1_gnt),
        .o_r1_rvalid(r1_rvalid),
        .o_rdata    (rdata),
        .o_ram_addr (ram_addr),
        .o_ram_data (ram_data),
        .o_ram_wren (ram_wren),
        .i_ram_q    (ram_q),
        .o_busy     (busy)
    );

    // RAM model: registered address/data/wren, q follows the registered address.
    logic [7:0] mem [32];
    logic [4:0] ram_addr_q;
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_addr_q <= ram_addr;
    end
    assign ram_q = mem[ram_addr_q];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("idle_reached", busy, 0);
    endtask

    // Issue one command and wait (bounded) for its grant; reads go to the scoreboard.
    task automatic do_cmd(input int c, input logic we, input logic [4:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd, input int exp_lat, output int gcyc);
        int   n   = 0;
        logic got = 1'b0;
        if (c == 0) begin
            r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d;
        end else begin
            r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d;
        end
        while (!got && n < 20) begin
            tick();
            n++;
            got = (c == 0) ? r0_gnt : r1_gnt;
        end
        chk("gnt_seen", got, 1);
        if (exp_lat > 0) chk("gnt_latency", n, exp_lat);
        chk("issue_wren", ram_wren, we);
        chk("issue_addr", ram_addr, a);
        if (we) chk("issue_data", ram_data, d);
        if (got && !we) sb.push_back('{c, exp_rd, cyc + 2});
        gcyc = cyc;
        if (c == 0) r0_req = 1'b0;
        else r1_req = 1'b0;
    endtask

    // Read-return monitor: order, owner, data and latency against the scoreboard.
    always @(posedge clk) begin
        #1;
        chk("gnt_exclusive", r0_gnt & r1_gnt, 0);
        if (r0_rvalid | r1_rvalid) begin
            chk("rvalid_exclusive", r0_rvalid & r1_rvalid, 0);
            chk("rvalid_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("rvalid_owner", r1_rvalid, mon_e.owner);
                chk("rdata", rdata, mon_e.data);
                chk("rvalid_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g1, g2, grants, exp_owner, owner;

        rst = 1'b1;
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_wren", ram_wren, 0);
        chk("rst_gnt", {r0_gnt, r1_gnt}, 0);
        chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_data", ram_data, 0);

        // Write then read back through r0 with exact gnt latency.
        do_cmd(0, 1'b1, 5'h03, 8'hA5, 8'h00, 1, g1);
        wait_idle();
        do_cmd(0, 1'b0, 5'h03, 8'h00, 8'hA5, 1, g1);
        wait_idle();

        // Simultaneous reads: r0 first, then r1.
        do_cmd(0, 1'b1, 5'h01, 8'h11, 8'h00, 0, g1);
        wait_idle();
        do_cmd(0, 1'b1, 5'h02, 8'h22, 8'h00, 0, g1);
        wait_idle();
        r0_req = 1; r0_we = 0; r0_addr = 5'h01;
        r1_req = 1; r1_we = 0; r1_addr = 5'h02;
        tick();
        chk("tie_gnt0", r0_gnt, 1);
        chk("tie_gnt1_low", r1_gnt, 0);
        if (r0_gnt) sb.push_back('{0, 8'h11, cyc + 2});
        r0_req = 0;
        tick();
        tick();
        tick();
        chk("tie_gnt1", r1_gnt, 1);
        if (r1_gnt) sb.push_back('{1, 8'h22, cyc + 2});
        r1_req = 0;
        wait_idle();

        // Continuous contention.
        r0_req = 1; r0_we = 0; r0_addr = 5'h01;
        r1_req = 1; r1_we = 0; r1_addr = 5'h02;
        grants = 0;
        exp_owner = 0;
        for (int i = 0; i < 30 && grants < 4; i++) begin
            tick();
            if (r0_gnt || r1_gnt) begin
                owner = r1_gnt ? 1 : 0;
                chk("contention_owner", owner, exp_owner);
                sb.push_back('{owner, (owner == 1) ? 8'h22 : 8'h11, cyc + 2});
                grants++;
`ifdef RAM_ARB_RR_EN
                exp_owner = 1 - exp_owner;
`endif
            end
        end
        chk("contention_grants", grants, 4);
        r0_req = 0;
        r1_req = 0;
        wait_idle();

        // Back-to-back writes at the address extremes, then readback.
        do_cmd(1, 1'b1, 5'h1F, 8'h7E, 8'h00, 1, g1);
        do_cmd(1, 1'b1, 5'h00, 8'h81, 8'h00, 0, g2);
        chk("b2b_spacing", g2 - g1, 2);
        wait_idle();
        do_cmd(1, 1'b0, 5'h1F, 8'h00, 8'h7E, 1, g1);
        do_cmd(1, 1'b0, 5'h00, 8'h00, 8'h81, 0, g1);
        wait_idle();
        tick();
        tick();

        // Reset held two cycles in the middle of write traffic.
        r0_req = 1; r0_we = 1; r0_addr = 5'h09; r0_wdata = 8'h33;
        r1_req = 1; r1_we = 1; r1_addr = 5'h0A; r1_wdata = 8'h44;
        tick();
        r0_req = 0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        r1_req = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_wren", ram_wren, 0);
        chk("midrst_gnt", {r0_gnt, r1_gnt}, 0);
        chk("midrst_rvalid", {r0_rvalid, r1_rvalid}, 0);
        chk("midrst_rdata", rdata, 0);
        chk("midrst_ram_addr", ram_addr, 0);
        chk("midrst_ram_data", ram_data, 0);

        // Reset during ISSUE of a write must suppress it.
        do_cmd(0, 1'b1, 5'h04, 8'h5A, 8'h00, 1, g1);
        wait_idle();
        r0_req = 1; r0_we = 1; r0_addr = 5'h04; r0_wdata = 8'hFF;
        tick();
        chk("rst_issue_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_issue_wren", ram_wren, 0);
        chk("rst_issue_gnt", r0_gnt, 0);
        tick();
        rst = 1'b0;
        r0_req = 0;
        chk("rst_issue_mem", mem[4], 8'h5A);
        do_cmd(0, 1'b0, 5'h04, 8'h00, 8'h5A, 1, g1);
        wait_idle();
        tick();
        tick();

        // Reset during WAIT of a read drops the rvalid.
        r0_req = 1; r0_we = 0; r0_addr = 5'h04;
        tick();
        chk("rst_wait_gnt", r0_gnt, 1);
        r0_req = 0;
        tick();
        chk("rst_wait_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_wait_rvalid", r0_rvalid, 0);
        chk("rst_wait_rdata", rdata, 0);
        tick();
        chk("rst_wait_rvalid_next", r0_rvalid, 0);

        repeat (5) tick();
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
